bcd_score_counter: RTL
======================

# bcd_score_counter

Parametrised decimal (BCD) game-score counter for the Dino game datapath. It tracks game state (idle/running/over) from the start and over pulses and advances a DIGITS-wide packed BCD score on every TICK_DIV-th end-of-frame tick. It supports saturate or wrap at the maximum score, emits milestone and rollover pulses for the audio and display blocks, and optionally keeps a high score. Its outputs feed the seven-segment/sprite score renderer and the speed-up logic.

## Interface
- DIGITS, 4: number of BCD digits; legal range 1–8.
- TICK_DIV, 1: score increments once per TICK_DIV qualifying game_ticks; legal range 1–255.
- WRAP, 0: 0 = saturate at all-9s; 1 = wrap to all-0s.
- MILESTONE_DIGIT, 2: digit index whose increment raises milestone (2 = every 100 points); must be < DIGITS.

- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- game_start  in  1  one-cycle pulse: begin a new game.
- game_over  in  1  one-cycle pulse: end the current game.
- game_tick  in  1  one-cycle end-of-frame pulse (60 Hz).
- score  out  4*DIGITS  packed BCD; digit 0 is in bits [3:0].
- active  out  1  high while state is RUN.
- milestone  out  1  one-cycle pulse when digit MILESTONE_DIGIT increments or carries.
- at_max  out  1  level: score is all 9s (WRAP=0 only; tied 0 when WRAP=1).
- rollover  out  1  one-cycle pulse when score wraps 9…9 → 0…0 (WRAP=1 only).
- hi_score  out  4*DIGITS  best completed score (see Configuration).
- new_record  out  1  one-cycle pulse when hi_score is updated.

## Operation
- States:
  - IDLE (after reset).
  - RUN.
  - OVER: score is frozen and displayed.
- Transitions:
  - IDLE/OVER + game_start → RUN. On the same edge, score and the tick prescaler clear to 0.
  - RUN + game_over → OVER.
  - RUN + game_start (no game_over) → stays in RUN and restarts: score and prescaler clear.
  - Simultaneous start and over:
    - In RUN, game_over wins.
    - In IDLE/OVER, game_start wins.
- Prescaler:
  - Counts qualifying ticks 0..TICK_DIV-1. A tick qualifies when the state is RUN and neither game_start nor game_over is high in that cycle.
  - On a qualifying tick with prescaler == TICK_DIV-1: prescaler → 0 and score increments by 1.
  - Otherwise a qualifying tick increments the prescaler.
  - With TICK_DIV=1 every qualifying tick increments the score.
- BCD increment:
  - Single-cycle ripple. Digit 0 always increments; digit k increments iff all digits below it are 9. Any digit passing 9 → 0 carries.
  - No digit ever holds a value above 9.
- Maximum (all digits 9) with an increment pending:
  - WRAP=0: score holds and at_max stays high; no milestone is raised.
  - WRAP=1: score → all 0 and rollover pulses. milestone pulses too, because digit MILESTONE_DIGIT changes.
- milestone: pulses on any increment that changes digit MILESTONE_DIGIT, except the WRAP=0 hold case.
- Reset behaviour: asserting rst_n low in any state, mid-game included, returns the block to IDLE on the next clock edge. Reset values:
  - score = 0, prescaler = 0, hi_score = 0.
  - active = 0, milestone = 0, at_max = 0, rollover = 0, new_record = 0.

## Timing
- All outputs are registered.
- score changes on the clk edge that samples the qualifying tick: latency 1 cycle from tick to new score.
- milestone and rollover are asserted in the same cycle as the score value that caused them, and last exactly 1 cycle.
- active rises or falls on the edge that samples game_start or game_over.
- at_max is a combinational compare of the registered score, re-registered so it is valid 1 cycle after score reaches max.
- hi_score and new_record update on the edge after OVER is entered (compare takes 1 cycle).
- Input pulses longer than 1 cycle are not supported. Each high cycle is treated as a separate event.

## Configuration
- Macro: SCORE_HISCORE_EN.
- Defined:
  - On the cycle after entering OVER, if score > hi_score (a plain unsigned compare of the packed BCD is valid), then hi_score ← score and new_record pulses for 1 cycle.
  - hi_score survives game_start and is cleared only by rst_n.
  - Games aborted by restart in RUN never update hi_score.
- Undefined: no hi_score register is built; hi_score is driven constant 0 and new_record is driven constant 0.

## Test plan
- Reset, then game_start, then 12 game_ticks (DIGITS=4, TICK_DIV=1) → score = 16'h0012, active=1. Each update occurs 1 cycle after its tick.
- TICK_DIV=3, game_start, then 9 ticks → score = 16'h0003; the prescaler reads 0 after the 9th tick.
- Preload near max via 9999 ticks:
  - WRAP=0: 10 further ticks → score stays 16'h9999, at_max=1, no rollover.
  - WRAP=1: 1 further tick → score 16'h0000, rollover and milestone each pulse once.
- Count 0→250 → milestone pulses exactly twice, at scores 100 and 200. game_over on the same cycle as a tick → tick is ignored and the score freezes at its prior value.
- SCORE_HISCORE_EN:
  - Game 1 ends at 0042 → hi_score=0042, new_record pulses.
  - Game 2 ends at 0030 → hi_score unchanged, no pulse.
  - rst_n low mid-game 3 → everything returns to 0 and the state returns to IDLE.
- Simultaneous start and over:
  - In OVER → enters RUN with score 0.
  - In RUN → enters OVER with score held.

Source files
------------

// File: rtl/bcd_score_counter_if.sv
// bcd_score_counter_if
// Purpose: bundles the game-event inputs and the score/status outputs of
//          bcd_score_counter into one port.
// Parameter: DIGITS - number of packed BCD digits carried on score/hi_score.
// Signals:
//   game_start, game_over, game_tick  one-cycle event pulses into the counter
//   score, hi_score                   packed BCD, digit 0 in bits [3:0]
//   active, at_max                    status levels
//   milestone, rollover, new_record   one-cycle event pulses out of the counter
// Modports: master drives the events (game logic side); slave is the counter.
interface bcd_score_counter_if #(
  parameter int DIGITS = 4
);
  logic                  game_start;
  logic                  game_over;
  logic                  game_tick;
  logic [4*DIGITS-1:0]   score;
  logic                  active;
  logic                  milestone;
  logic                  at_max;
  logic                  rollover;
  logic [4*DIGITS-1:0]   hi_score;
  logic                  new_record;

  modport master (
    output game_start, game_over, game_tick,
    input  score, active, milestone, at_max, rollover, hi_score, new_record
  );

  modport slave (
    input  game_start, game_over, game_tick,
    output score, active, milestone, at_max, rollover, hi_score, new_record
  );
endinterface

// File: rtl/bcd_score_counter.sv
// bcd_score_counter
// Purpose: decimal game-score counter for the Dino game. Tracks the game state
//          (IDLE/RUN/OVER) from start/over pulses and advances a packed BCD
//          score once every TICK_DIV qualifying end-of-frame ticks.
// Parameters:
//   DIGITS          number of BCD digits (1..8)
//   TICK_DIV        qualifying ticks per score increment (1..255)
//   WRAP            0 = saturate at all 9s, 1 = wrap to all 0s
//   MILESTONE_DIGIT digit index whose change raises milestone (< DIGITS)
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    bcd_score_counter_if.slave: game_start/game_over/game_tick in;
//          score, active, milestone, at_max, rollover, hi_score, new_record out
// Optional feature: define SCORE_HISCORE_EN to build the high-score register.
//   Without it hi_score and new_record are constant 0.
module bcd_score_counter #(
  parameter int DIGITS          = 4,
  parameter int TICK_DIV        = 1,
  parameter int WRAP            = 0,
  parameter int MILESTONE_DIGIT = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  bcd_score_counter_if.slave  bus
);

  localparam int         W          = 4 * DIGITS;
  localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   score_q, score_d;
  logic [7:0]     presc_q, presc_d;
  logic           active_q;
  logic           milestone_q, milestone_d;
  logic           rollover_q, rollover_d;
  logic           at_max_q;

  logic [W-1:0]   inc_score;
  logic           all_nines;
  logic           ms_carry;

  // Ripple BCD increment of the current score. A digit advances only while
  // the carry is still set, i.e. every digit below it was 9. The carry left
  // over after the top digit means the whole score is 9...9. ms_carry is the
  // carry arriving at the milestone digit, which is exactly when that digit
  // changes value.
  always_comb begin
    inc_score = score_q;
    all_nines = 1'b1;
    ms_carry  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (k == MILESTONE_DIGIT) ms_carry = all_nines;
      if (all_nines) begin
        if (score_q[4*k +: 4] == 4'd9) begin
          inc_score[4*k +: 4] = 4'd0;
        end else begin
          inc_score[4*k +: 4] = score_q[4*k +: 4] + 4'd1;
          all_nines           = 1'b0;
        end
      end
    end
  end

  // Next-state logic. In RUN game_over takes priority over game_start; in
  // IDLE/OVER only game_start matters. A tick only qualifies in RUN when no
  // start/over is present in the same cycle.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    presc_d     = presc_q;
    milestone_d = 1'b0;
    rollover_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.game_over) begin
          state_d = OVER;
        end else if (bus.game_start) begin
          score_d = '0;
          presc_d = '0;
        end else if (bus.game_tick) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            // Saturating build holds at 9...9 without any pulse.
            if (!(all_nines && (WRAP == 0))) begin
              score_d     = inc_score;
              milestone_d = ms_carry;
              rollover_d  = all_nines;
            end
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
      end
      IDLE, OVER: begin
        if (bus.game_start) begin
          state_d = RUN;
          score_d = '0;
          presc_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. at_max is the all-9s compare of the score
  // register delayed by one cycle; it never rises in the wrapping build.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      score_q     <= '0;
      presc_q     <= '0;
      active_q    <= 1'b0;
      milestone_q <= 1'b0;
      rollover_q  <= 1'b0;
      at_max_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      presc_q     <= presc_d;
      active_q    <= (state_d == RUN);
      milestone_q <= milestone_d;
      rollover_q  <= rollover_d;
      at_max_q    <= (WRAP == 0) && all_nines;
    end
  end

  assign bus.score     = score_q;
  assign bus.active    = active_q;
  assign bus.milestone = milestone_q;
  assign bus.rollover  = rollover_q;
  assign bus.at_max    = at_max_q;

`ifdef SCORE_HISCORE_EN
  logic         enter_over_q;
  logic [W-1:0] hi_q;
  logic         new_record_q;

  // enter_over_q marks the first cycle spent in OVER; the compare happens on
  // the following edge against the frozen final score. Packed BCD orders the
  // same way as its decimal value, so a plain unsigned compare is enough.
  // A restart inside RUN never passes through OVER and so never records.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enter_over_q <= 1'b0;
      hi_q         <= '0;
      new_record_q <= 1'b0;
    end else begin
      enter_over_q <= (state_q == RUN) && bus.game_over;
      new_record_q <= 1'b0;
      if (enter_over_q && (score_q > hi_q)) begin
        hi_q         <= score_q;
        new_record_q <= 1'b1;
      end
    end
  end

  assign bus.hi_score   = hi_q;
  assign bus.new_record = new_record_q;
`else
  assign bus.hi_score   = '0;
  assign bus.new_record = 1'b0;
`endif

endmodule
